// File: rtl/io_defs.sv
// Shared IO-space constants: address prefix, register offsets, status bits, TX state encoding.
package io_defs;

  localparam logic [3:0] IO_PREFIX     = 4'h8;

  localparam logic [7:0] OFF_STATUS    = 8'h00;
  localparam logic [7:0] OFF_RX_DATA   = 8'h04;
  localparam logic [7:0] OFF_TX_DATA   = 8'h08;
  localparam logic [7:0] OFF_CYCLE_CNT = 8'h10;
  localparam logic [7:0] OFF_INSTR_CNT = 8'h14;
  localparam logic [7:0] OFF_CNT_RST   = 8'h18;

  localparam int unsigned ST_TX_READY  = 0;
  localparam int unsigned ST_RX_VALID  = 1;
  localparam int unsigned ST_TX_OVF    = 2;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BYTE_W       = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_FULL = 1'b1
  } tx_state_e;

  // Decoded IO access for the current cycle
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] off;
  } io_req_t;

endpackage

// File: rtl/io_rx_fifo.sv
// Small circular FIFO buffering received UART bytes; full/empty are registered.
module io_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage needs no reset; empty_o guards every read of it
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped IO controller: UART TX holding register, RX FIFO, cycle/instruction counters.
module io_controller #(
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [3:0]  IO_PREFIX = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [3:0]  io_trans,
  input  logic        io_recv,
  input  logic [31:0] wdata,
  input  logic        instr_retired,
  output logic [31:0] Received,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  import io_defs::*;

  io_req_t           req;
  logic              status_rd, rx_rd, tx_wr, cnt_rst;
  tx_state_e         tx_state_q, tx_state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              ovf_set;
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] received_q, received_d;
  logic [DATA_W-1:0] rdata;
  logic [BYTE_W-1:0] rx_head;
  logic              rx_full, rx_empty, rx_push;
  logic              unused_addr;

  assign unused_addr = ^A[27:8];

  // Strobes outside IO space are dropped entirely
  always_comb begin
    req.rd  = io_recv & (A[31:28] == IO_PREFIX);
    req.wr  = (|io_trans) & (A[31:28] == IO_PREFIX);
    req.off = A[7:0];
  end

  assign status_rd = req.rd & (req.off == OFF_STATUS);
  assign rx_rd     = req.rd & (req.off == OFF_RX_DATA);
  assign tx_wr     = req.wr & (req.off == OFF_TX_DATA);
  assign cnt_rst   = req.wr & (req.off == OFF_CNT_RST);

  // TX holding register FSM and sticky overflow flag
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    ovf_set    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_state_d = TX_FULL;
          tx_data_d  = wdata[BYTE_W-1:0];
        end
      end
      TX_FULL: begin
        if (uart_tx_ready) begin
          if (tx_wr) tx_data_d = wdata[BYTE_W-1:0];
          else       tx_state_d = TX_IDLE;
        end else if (tx_wr) begin
          ovf_set = 1'b1;
        end
      end
    endcase
    tx_valid_d = (tx_state_d == TX_FULL);
    // A new overflow outranks the clear-on-read
    if (ovf_set)        tx_ovf_d = 1'b1;
    else if (status_rd) tx_ovf_d = 1'b0;
    else                tx_ovf_d = tx_ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  assign rx_push = uart_rx_valid & ~rx_full;

  io_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (BYTE_W)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .pop_i   (rx_rd),
    .data_i  (uart_rx_data),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Free-running counters; a clear write wins over the increment
  always_comb begin
    cycle_d = cycle_q + DATA_W'(1);
    instr_d = instr_q + DATA_W'(instr_retired);
    if (cnt_rst) begin
      cycle_d = '0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  // Read mux; non-IO and unmapped reads return zero
  always_comb begin
    rdata = '0;
    if (req.rd) begin
      unique case (req.off)
        OFF_STATUS: begin
          rdata[ST_TX_READY] = (tx_state_q == TX_IDLE);
          rdata[ST_RX_VALID] = ~rx_empty;
          rdata[ST_TX_OVF]   = tx_ovf_q;
        end
        OFF_RX_DATA:   if (!rx_empty) rdata = DATA_W'(rx_head);
        OFF_CYCLE_CNT: rdata = cycle_q;
        OFF_INSTR_CNT: rdata = instr_q;
        default:       rdata = '0;
      endcase
    end
    received_d = io_recv ? rdata : received_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) received_q <= '0;
    else        received_q <= received_d;
  end

  assign Received      = received_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_rx_ready = ~rx_full;

endmodule

// File: tb/tb_io_controller.sv
// Directed self-checking bench for io_controller; inputs driven and outputs sampled on negedge.
module tb_io_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [3:0]  io_trans;
  logic        io_recv;
  logic [31:0] wdata;
  logic        instr_retired;
  logic [31:0] Received;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  io_controller #(.RX_DEPTH(4), .IO_PREFIX(4'h8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .io_trans      (io_trans),
    .io_recv       (io_recv),
    .wdata         (wdata),
    .instr_retired (instr_retired),
    .Received      (Received),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr);
    A       = addr;
    io_recv = 1'b1;
    tick();
    io_recv = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    A        = addr;
    wdata    = data;
    io_trans = 4'hF;
    tick();
    io_trans = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; A = '0; io_trans = '0; io_recv = 1'b0; wdata = '0;
    instr_retired = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_received", Received, 32'h0);
    chk("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("rst_tx_data", 32'(uart_tx_data), 32'h0);
    rst_n = 1'b1;
    tick();

    rd(32'h8000_0000);
    chk("status_idle", Received, 32'h1);

    // TX stall, overflow, release
    wr(32'h8000_0008, 32'h0000_0041);
    chk("tx_valid_s1", 32'(uart_tx_valid), 32'h1);
    chk("tx_data_s1", 32'(uart_tx_data), 32'h41);
    tick();
    chk("tx_data_s2", 32'(uart_tx_data), 32'h41);
    wr(32'h8000_0008, 32'h0000_0099);
    chk("tx_data_ovf", 32'(uart_tx_data), 32'h41);
    chk("tx_valid_s3", 32'(uart_tx_valid), 32'h1);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("tx_valid_drop", 32'(uart_tx_valid), 32'h0);
    rd(32'h8000_0000);
    chk("status_ovf", Received, 32'h5);
    rd(32'h8000_0000);
    chk("status_ovf_clr", Received, 32'h1);
    tick();
    chk("received_hold", Received, 32'h1);

    // TX back-to-back
    wr(32'h8000_0008, 32'h0000_0055);
    uart_tx_ready = 1'b1;
    wr(32'h8000_0008, 32'h0000_0066);
    chk("b2b_valid", 32'(uart_tx_valid), 32'h1);
    chk("b2b_data", 32'(uart_tx_data), 32'h66);
    tick();
    uart_tx_ready = 1'b0;
    chk("b2b_done", 32'(uart_tx_valid), 32'h0);
    rd(32'h8000_0000);
    chk("b2b_no_ovf", Received, 32'h1);

    // RX fill to full, drain, overdrain
    uart_rx_valid = 1'b1;
    for (int b = 8'h10; b <= 8'h13; b++) begin
      uart_rx_data = 8'(b);
      tick();
    end
    chk("rx_full_ready", 32'(uart_rx_ready), 32'h0);
    uart_rx_data = 8'h14;
    rd(32'h8000_0000);
    chk("status_rx", Received, 32'h3);
    rd(32'h8000_0004);
    chk("rx_pop0", Received, 32'h10);
    chk("rx_ready_after_pop", 32'(uart_rx_ready), 32'h1);
    tick();
    chk("rx_refull", 32'(uart_rx_ready), 32'h0);
    uart_rx_valid = 1'b0;
    rd(32'h8000_0004); chk("rx_pop1", Received, 32'h11);
    rd(32'h8000_0004); chk("rx_pop2", Received, 32'h12);
    rd(32'h8000_0004); chk("rx_pop3", Received, 32'h13);
    rd(32'h8000_0004); chk("rx_pop4", Received, 32'h14);
    rd(32'h8000_0004); chk("rx_empty_rd", Received, 32'h0);
    chk("rx_ready_empty", 32'(uart_rx_ready), 32'h1);

    // Simultaneous push and pop with two entries held
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h20; tick();
    uart_rx_data = 8'h21; tick();
    uart_rx_data = 8'h22;
    rd(32'h8000_0004);
    chk("rx_pushpop", Received, 32'h20);
    uart_rx_valid = 1'b0;
    rd(32'h8000_0004); chk("rx_pp1", Received, 32'h21);
    rd(32'h8000_0004); chk("rx_pp2", Received, 32'h22);
    rd(32'h8000_0004); chk("rx_pp_empty", Received, 32'h0);

    // Non-IO accesses are ignored
    wr(32'h0000_0008, 32'h0000_0012);
    chk("nonio_wr", 32'(uart_tx_valid), 32'h0);

    // Counters
    wr(32'h8000_0018, 32'h0);
    for (int i = 0; i < 100; i++) begin
      instr_retired = (i < 37);
      tick();
    end
    instr_retired = 1'b0;
    rd(32'h8000_0010);
    chk("cycle_cnt", Received, 32'd100);
    rd(32'h8000_0014);
    chk("instr_cnt", Received, 32'd37);
    rd(32'h8000_000C);
    chk("unmapped_rd", Received, 32'h0);
    rd(32'h8000_0010);
    rd(32'h0000_0010);
    chk("nonio_rd", Received, 32'h0);
    instr_retired = 1'b1;
    wr(32'h8000_0018, 32'h0);
    instr_retired = 1'b0;
    rd(32'h8000_0014);
    chk("instr_clr", Received, 32'h0);
    rd(32'h8000_0010);
    chk("cycle_clr", Received, 32'h1);

    // Asynchronous reset mid-handshake
    wr(32'h8000_0008, 32'h0000_0077);
    uart_rx_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      uart_rx_data = 8'(b);
      tick();
    end
    uart_rx_valid = 1'b0;
    chk("pre_rst_valid", 32'(uart_tx_valid), 32'h1);
    chk("pre_rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    rd(32'h8000_0000);
    chk("pre_rst_status", Received, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("arst_tx_data", 32'(uart_tx_data), 32'h0);
    chk("arst_rx_ready", 32'(uart_rx_ready), 32'h1);
    chk("arst_received", Received, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(32'h8000_0000);
    chk("post_rst_status", Received, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Memory-mapped IO controller between the CPU's IO address path and the UART byte transmitter/receiver, plus two performance counters.
- Decodes IO loads and stores, buffers received bytes in a small RX FIFO, and holds one outgoing TX byte.
- Sequences the UART ready/valid handshakes and returns registered read data to the writeback stage.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of two, ≥2)
- IO_PREFIX, 4'h8, value of A[31:28] that selects IO space

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- A  in  32  CPU load/store address (word aligned)
- io_trans  in  4  store byte-enable mask; any bit set = IO store this cycle
- io_recv  in  1  IO load strobe this cycle
- wdata  in  32  store data
- instr_retired  in  1  one instruction retired this cycle
- Received  out  32  read data, valid the cycle after io_recv
- uart_tx_data  out  8  byte to transmit
- uart_tx_valid  out  1  TX byte pending
- uart_tx_ready  in  1  transmitter accepts byte
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte present
- uart_rx_ready  out  1  controller accepts received byte

Behaviour:
- Access is active only when A[31:28]==IO_PREFIX; otherwise strobes are ignored and Received is 0.
- Address map (A[7:0]):
  - 0x00 status (read): bit0 tx_ready = !tx_full; bit1 rx_valid = !rx_empty; bit2 tx_overflow (sticky); others 0.
  - 0x04 RX data (read): {24'b0, head byte}; pops the FIFO.
  - 0x08 TX data (write): loads wdata[7:0].
  - 0x10 cycle counter (read).
  - 0x14 instruction counter (read).
  - 0x18 counter reset (write, data ignored).
  - Unmapped offsets read 0; writes to them are ignored.
- Read latency is 1: Received is registered from the address sampled with io_recv and holds its value until the next io_recv. Both io_recv and io_trans asserted together: the store and the load are both performed.
- TX state machine, states IDLE and FULL:
  - IDLE: TX write → FULL, byte latched.
  - FULL: uart_tx_valid=1. uart_tx_valid & uart_tx_ready → IDLE, unless a TX write occurs the same cycle, which loads the new byte and stays FULL (back-to-back).
  - TX write in FULL without a handshake: byte dropped, held byte unchanged, tx_overflow set.
  - tx_overflow clears on a status read. A status read in the same cycle as a new overflow returns 0 in bit2 and leaves it set.
- RX FIFO:
  - uart_rx_ready = !rx_full. Push on uart_rx_valid & uart_rx_ready.
  - Pop on an RX data read when not empty.
  - RX data read when empty returns 0 with no pointer change.
  - Push and pop in the same cycle: both happen, count unchanged. When full, the pop proceeds and no push occurs that cycle.
  - Pointers wrap modulo RX_DEPTH; count is tracked in a $clog2(RX_DEPTH)+1 bit counter.
- Counters:
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Cycle counter increments every cycle; instruction counter increments on instr_retired.
  - A write to 0x18 sets both to 0; clear wins over a same-cycle increment.
- Reset (asynchronous, any time, including mid-handshake):
  - TX → IDLE, uart_tx_valid=0, uart_tx_data=0.
  - FIFO empty, uart_rx_ready=1.
  - tx_overflow=0, both counters 0, Received=0.

Decomposition:
- Shared package io_defs: IO_PREFIX, the offset constants (STATUS, RX_DATA, TX_DATA, CYCLE_CNT, INSTR_CNT, CNT_RST), status bit indices, TX state encoding.
- One sub-module: io_rx_fifo, parameterised by depth and width, with push/pop/full/empty/head.

Test Plan:
- Reset, then status read at 0x80000000 → Received=0x00000001 on the next cycle; uart_rx_ready=1; uart_tx_valid=0.
- Write 0x41 to 0x80000008 with uart_tx_ready=0 for 3 cycles, then 1 → uart_tx_valid=1 and uart_tx_data=0x41 through the stall, then valid drops. A second write during the stall → status bit2=1; the next status read clears it.
- Push 0x10,0x11,0x12,0x13,0x14 on the RX port → uart_rx_ready=0 after the 4th. Reads of 0x80000004 return 0x10..0x13 in order, 0x14 is accepted after the first pop, and a 6th read returns 0.
- Simultaneous RX push and RX data read with FIFO holding 2 entries → oldest byte returned, count stays 2.
- Run 100 cycles with instr_retired high on 37 of them, read 0x80000010 and 0x80000014 → values consistent with 100/37 plus read-time offsets. Write 0x80000018 → both read back as small values counted from 0.
- Assert rst_n=0 while in FULL with FIFO count 3 → uart_tx_valid=0, uart_rx_ready=1, and the next status read returns 0x00000001.
